// File: rtl/fb_pkg.sv
// Shared widths, FSM encoding and read-pipeline depth for the banked VGA frame buffer.
package fb_pkg;

   localparam int DEF_ADDR_WIDTH = 13;
   localparam int DEF_DATA_WIDTH = 12;
   localparam int DEF_DEPTH      = 4800;
   localparam int DEF_BANKS      = 16;
   localparam int DEF_BANK_WIDTH = 4;

   localparam int RD_LATENCY = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } fb_state_t;

endpackage

// File: rtl/fb_bank.sv
// One simple-dual-port line-group bank: synchronous write port, registered read-first read port.
module fb_bank
   import fb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Both ports share one block so a same-address read returns the pre-write word.
   always_ff @(posedge clk) begin
      if (i_we) begin
         mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         o_rd_data <= mem[i_rd_addr];
      end
   end

endmodule

// File: rtl/banked_framebuffer.sv
// Multi-bank pixel frame buffer: handshake/broadcast writes, hardware clear sweep,
// and a two-stage read path into a registered bank mux.
module banked_framebuffer
   import fb_pkg::*;
#(
   parameter int                          ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int                          DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int                          DEPTH          = DEF_DEPTH,
   parameter int                          BANKS          = DEF_BANKS,
   parameter int                          BANK_WIDTH     = DEF_BANK_WIDTH,
   parameter logic [DEF_DATA_WIDTH-1:0]   CLEAR_VALUE    = '0,
   parameter bit                          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic                  i_wr_broadcast,
   input  logic [BANK_WIDTH-1:0] i_wr_bank,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_clear,
   output logic                  o_busy,
   input  logic                  i_rd_en,
   input  logic [BANK_WIDTH-1:0] i_rd_bank,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid,
   output logic                  o_wr_err
);

   localparam fb_state_t             RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [BANK_WIDTH:0]   BANKS_EXT   = (BANK_WIDTH + 1)'(BANKS);

   logic [1:0]            rst_sync;
   logic                  rst_n;
   fb_state_t             state;
   fb_state_t             next_state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  clearing;
   logic                  wr_fire;
   logic                  wr_addr_ok;
   logic                  wr_bank_ok;
   logic [BANKS-1:0]      bank_we;
   logic [ADDR_WIDTH-1:0] ram_wr_addr;
   logic [DATA_WIDTH-1:0] ram_wr_data;
   logic                  rd_addr_ok;
   logic                  rd_bank_ok;
   logic [RD_LATENCY-1:0] rd_en_pipe;
   logic [BANK_WIDTH-1:0] rd_bank_q;
   logic                  rd_oor_q;
   logic [DATA_WIDTH-1:0] bank_q [BANKS];

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET_STATE;
      end else begin
         state <= next_state;
      end
   end

   // Handshake and busy are held low while reset is active, even if the parked state is CLEAR.
   always_comb begin
      next_state = state;
      o_wr_ready = 1'b0;
      o_busy     = 1'b0;
      clearing   = 1'b0;
      case (state)
         ST_IDLE: begin
            o_wr_ready = rst_n;
            if (i_clear) begin
               next_state = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            o_busy   = rst_n;
            clearing = rst_n;
            if (clr_cnt == LAST_ADDR) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
      end else if (i_clear) begin
         clr_cnt <= '0;
      end
   end

   assign wr_fire     = i_wr_valid && o_wr_ready;
   assign wr_addr_ok  = {1'b0, i_wr_addr} < DEPTH_EXT;
   assign wr_bank_ok  = i_wr_broadcast || ({1'b0, i_wr_bank} < BANKS_EXT);
   assign ram_wr_addr = clearing ? clr_cnt : i_wr_addr;
   assign ram_wr_data = clearing ? CLEAR_VALUE[DATA_WIDTH-1:0] : i_wr_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_wr_err <= 1'b0;
      end else if (wr_fire && !(wr_addr_ok && wr_bank_ok)) begin
         o_wr_err <= 1'b1;
      end
   end

   assign rd_addr_ok = {1'b0, i_rd_addr} < DEPTH_EXT;
   assign rd_bank_ok = {1'b0, i_rd_bank} < BANKS_EXT;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      assign bank_we[b] = clearing ||
                          (wr_fire && wr_addr_ok && wr_bank_ok &&
                           (i_wr_broadcast || (i_wr_bank == BANK_WIDTH'(b))));

      fb_bank #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_bank (
         .clk       (clk),
         .i_we      (bank_we[b]),
         .i_wr_addr (ram_wr_addr),
         .i_wr_data (ram_wr_data),
         .i_rd_en   (i_rd_en && rd_addr_ok),
         .i_rd_addr (i_rd_addr),
         .o_rd_data (bank_q[b])
      );
   end

   // Bank select and range flag travel alongside the RAM stage; data holds when no read lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_pipe <= '0;
         rd_bank_q  <= '0;
         rd_oor_q   <= 1'b0;
         o_rd_data  <= '0;
      end else begin
         rd_en_pipe <= {rd_en_pipe[RD_LATENCY-2:0], i_rd_en};
         rd_bank_q  <= i_rd_bank;
         rd_oor_q   <= !(rd_addr_ok && rd_bank_ok);
         if (rd_en_pipe[0]) begin
            o_rd_data <= rd_oor_q ? '0 : bank_q[rd_bank_q];
         end
      end
   end

   assign o_rd_valid = rd_en_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_banked_framebuffer.sv
// Self-checking bench for banked_framebuffer: a per-cycle array model plus directed literal checks.
module tb_banked_framebuffer;

   localparam int AW    = 13;
   localparam int DW    = 12;
   localparam int DEPTH = 4800;
   localparam int BANKS = 16;
   localparam int BW    = 4;

   logic          clk;
   logic          i_rst_n;
   logic          i_wr_valid;
   logic          o_wr_ready;
   logic          i_wr_broadcast;
   logic [BW-1:0] i_wr_bank;
   logic [AW-1:0] i_wr_addr;
   logic [DW-1:0] i_wr_data;
   logic          i_clear;
   logic          o_busy;
   logic          i_rd_en;
   logic [BW-1:0] i_rd_bank;
   logic [AW-1:0] i_rd_addr;
   logic [DW-1:0] o_rd_data;
   logic          o_rd_valid;
   logic          o_wr_err;

   int checks   = 0;
   int failures = 0;

   banked_framebuffer #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .DEPTH          (DEPTH),
      .BANKS          (BANKS),
      .BANK_WIDTH     (BW),
      .CLEAR_VALUE    (12'h000),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk            (clk),
      .i_rst_n        (i_rst_n),
      .i_wr_valid     (i_wr_valid),
      .o_wr_ready     (o_wr_ready),
      .i_wr_broadcast (i_wr_broadcast),
      .i_wr_bank      (i_wr_bank),
      .i_wr_addr      (i_wr_addr),
      .i_wr_data      (i_wr_data),
      .i_clear        (i_clear),
      .o_busy         (o_busy),
      .i_rd_en        (i_rd_en),
      .i_rd_bank      (i_rd_bank),
      .i_rd_addr      (i_rd_addr),
      .o_rd_data      (o_rd_data),
      .o_rd_valid     (o_rd_valid),
      .o_wr_err       (o_wr_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: memory image, sticky error, and the two-cycle read delay line.
   logic [DW-1:0] model_mem [BANKS][DEPTH];
   bit            model_err;
   bit            exp_valid;
   logic [DW-1:0] exp_data;
   bit            s1_v, s2_v;
   logic [DW-1:0] s1_d, s2_d;

   function automatic void clear_model();
      for (int b = 0; b < BANKS; b++) begin
         for (int a = 0; a < DEPTH; a++) begin
            model_mem[b][a] = 12'h000;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (!i_rst_n) begin
         s1_v = 1'b0;
         s2_v = 1'b0;
         exp_valid = 1'b0;
         exp_data = '0;
         model_err = 1'b0;
         clear_model();
      end else begin
         exp_valid = s2_v;
         if (s2_v) exp_data = s2_d;
      end
      checkOutput("model_rd_valid", o_rd_valid, exp_valid);
      checkOutput("model_rd_data", o_rd_data, exp_data);
      checkOutput("model_wr_err", o_wr_err, model_err);
      if (i_rst_n) begin
         s2_v = s1_v;
         s2_d = s1_d;
         s1_v = i_rd_en;
         s1_d = (int'(i_rd_addr) < DEPTH && int'(i_rd_bank) < BANKS) ?
                model_mem[i_rd_bank][i_rd_addr] : 12'h000;
         if (i_wr_valid) begin
            if (int'(i_wr_addr) >= DEPTH || (!i_wr_broadcast && int'(i_wr_bank) >= BANKS)) begin
               model_err = 1'b1;
            end else if (i_wr_broadcast) begin
               for (int b = 0; b < BANKS; b++) model_mem[b][i_wr_addr] = i_wr_data;
            end else begin
               model_mem[i_wr_bank][i_wr_addr] = i_wr_data;
            end
         end
         if (i_clear) clear_model();
      end
   end

   task automatic applyStimulus(input bit wr, input bit bc, input int wb, input int wa, input int wd,
                                input bit rd, input int rb, input int ra, input bit clr);
      @(posedge clk);
      #1;
      i_wr_valid     = wr;
      i_wr_broadcast = bc;
      i_wr_bank      = BW'(wb);
      i_wr_addr      = AW'(wa);
      i_wr_data      = DW'(wd);
      i_rd_en        = rd;
      i_rd_bank      = BW'(rb);
      i_rd_addr      = AW'(ra);
      i_clear        = clr;
   endtask

   task automatic idle_cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_write(input bit bc, input int b, input int a, input int d);
      applyStimulus(1, bc, b, a, d, 0, 0, 0, 0);
      checkOutput("wr_ready", o_wr_ready, 1);
      idle_cycle();
   endtask

   task automatic do_read(input string name, input int b, input int a, input int expected);
      applyStimulus(0, 0, 0, 0, 0, 1, b, a, 0);
      idle_cycle();
      @(negedge clk);
      checkOutput({name, "_valid_early"}, o_rd_valid, 0);
      @(negedge clk);
      checkOutput({name, "_valid"}, o_rd_valid, 1);
      checkOutput({name, "_data"}, o_rd_data, expected);
   endtask

   task automatic wait_sweep(input string name);
      int n = 0;
      int guard = 0;
      bit ready_hi = 1'b0;
      @(negedge clk);
      while (!o_busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput({name, "_busy_start"}, o_busy, 1);
      while (o_busy && n < 6000) begin
         if (o_wr_ready) ready_hi = 1'b1;
         n++;
         @(negedge clk);
      end
      checkOutput({name, "_busy_cycles"}, n, DEPTH);
      checkOutput({name, "_ready_in_clear"}, ready_hi, 0);
      checkOutput({name, "_ready_after"}, o_wr_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      i_rst_n = 1'b0;
      i_wr_valid = 0; i_wr_broadcast = 0; i_wr_bank = '0; i_wr_addr = '0; i_wr_data = '0;
      i_rd_en = 0; i_rd_bank = '0; i_rd_addr = '0; i_clear = 0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_wr_ready", o_wr_ready, 0);
      checkOutput("rst_rd_valid", o_rd_valid, 0);
      checkOutput("rst_rd_data", o_rd_data, 0);
      checkOutput("rst_wr_err", o_wr_err, 0);
      @(posedge clk);
      #1 i_rst_n = 1'b1;
      wait_sweep("boot_sweep");
      do_read("rd_b7_4799", 7, 4799, 12'h000);

      do_write(0, 3, 100, 12'hABC);
      do_read("rd_b3_100", 3, 100, 12'hABC);
      do_read("rd_b4_100", 4, 100, 12'h000);
      do_read("rd_b3_100_again", 3, 100, 12'hABC);
      repeat (4) idle_cycle();
      @(negedge clk);
      checkOutput("rd_hold_data", o_rd_data, 12'hABC);
      checkOutput("rd_hold_valid", o_rd_valid, 0);

      do_write(1, 0, 5, 12'h5A5);
      do_read("bc_b0", 0, 5, 12'h5A5);
      do_read("bc_b8", 8, 5, 12'h5A5);
      do_read("bc_b15", 15, 5, 12'h5A5);

      do_write(0, 2, 9, 12'h222);
      applyStimulus(1, 0, 2, 9, 12'h111, 1, 2, 9, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 2, 9, 0);
      idle_cycle();
      @(negedge clk);
      checkOutput("collide_old_data", o_rd_data, 12'h222);
      @(negedge clk);
      checkOutput("collide_new_data", o_rd_data, 12'h111);

      do_write(0, 0, 4800, 12'h777);
      @(negedge clk);
      checkOutput("oor_wr_err", o_wr_err, 1);
      do_read("oor_pre_b3", 3, 100, 12'hABC);
      do_read("oor_rd_4800", 0, 4800, 12'h000);
      repeat (20) idle_cycle();
      @(negedge clk);
      checkOutput("oor_err_sticky", o_wr_err, 1);

      applyStimulus(0, 0, 0, 0, 0, 1, 0, 4000, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 4000, 0);
      repeat (998) @(posedge clk);
      #1 checkOutput("mid_sweep_busy", o_busy, 1);
      checkOutput("mid_sweep_valid", o_rd_valid, 1);
      @(posedge clk);
      #1;
      i_rst_n = 1'b0;
      i_rd_en = 1'b0;
      #1;
      checkOutput("abort_busy", o_busy, 0);
      checkOutput("abort_rd_valid", o_rd_valid, 0);
      checkOutput("abort_wr_err", o_wr_err, 0);
      repeat (3) @(posedge clk);
      #1 i_rst_n = 1'b1;
      wait_sweep("restart_sweep");
      do_read("post_clear_b3", 3, 100, 12'h000);
      do_read("post_clear_b0_5", 0, 5, 12'h000);

      repeat (3) idle_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
